// File: rtl/sram_req_pkg.sv
// -----------------------------------------------------------------------------
// sram_req_pkg
//   Shared definitions for the cache-side SRAM requester.
//   - sram_req_state_t   : controller FSM states (IDLE/WRITE/READ/RESP)
//   - sram_read_latency(): read latency (edges from address sample to data
//                          update) of an SRAM instance, i.e. its delay + 1.
// -----------------------------------------------------------------------------
package sram_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } sram_req_state_t;

  // Arrays up to this depth answer with zero extra delay; every doubling
  // beyond it adds one pipeline stage in the SRAM.
  localparam int SRAM_BASE_LOG_DEPTH = 9;

  // SRAM delay grows with depth beyond the base size and with each extra
  // port; the requester must wait delay+1 edges after the address is sampled.
  function automatic int sram_read_latency(input int log_depth, input int ports);
    int delay;
    delay = 0;
    if (log_depth > SRAM_BASE_LOG_DEPTH) begin
      delay = delay + (log_depth - SRAM_BASE_LOG_DEPTH);
    end else begin
      delay = delay + 0;
    end
    if (ports > 1) begin
      delay = delay + (ports - 1);
    end else begin
      delay = delay + 0;
    end
    return delay + 1;
  endfunction

endpackage

// File: rtl/sram_requester.sv
// -----------------------------------------------------------------------------
// sram_requester
//   Initiator end of the single-ported, fixed-latency SRAM interface. Accepts
//   one read-line or write-slice request at a time, drives the SRAM pins, counts
//   the SRAM read latency and returns read lines on a valid/ready channel.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   reqValid/Ready    : request handshake (reqReady high only in IDLE)
//   reqWrite          : 1 = write slice, 0 = read line
//   reqAddr           : line index
//   reqOffset         : slice index (writes only)
//   reqData           : write line, only slice reqOffset is meaningful
//   respValid/Ready   : read-response handshake
//   respData          : read line
//   sramReadAddr      : SRAM readAddr
//   sramWriteAddr     : SRAM writeAddr
//   sramWriteData     : SRAM writeData
//   sramWriteOffset   : SRAM writeOffset
//   sramWriteEnable   : SRAM writeEnable
//   sramReadData      : SRAM readData
// -----------------------------------------------------------------------------
module sram_requester
  import sram_req_pkg::*;
#(
  parameter int width         = 16,
  parameter int logDepth      = 9,
  parameter int logLineOffset = 3,
  parameter int readLatency   = sram_read_latency(logDepth, 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic                     reqWrite,
  input  logic [logDepth-1:0]      reqAddr,
  input  logic [logLineOffset-1:0] reqOffset,
  input  logic [width-1:0]         reqData,
  output logic                     respValid,
  input  logic                     respReady,
  output logic [width-1:0]         respData,
  output logic [logDepth-1:0]      sramReadAddr,
  output logic [logDepth-1:0]      sramWriteAddr,
  output logic [width-1:0]         sramWriteData,
  output logic [logLineOffset-1:0] sramWriteOffset,
  output logic                     sramWriteEnable,
  input  logic [width-1:0]         sramReadData
);

  localparam int CntW = $clog2(readLatency + 1);

  sram_req_state_t         r_state;
  logic [CntW-1:0]         r_cnt;
  logic                    r_resp_valid;
  logic [width-1:0]        r_resp_data;
  logic [logDepth-1:0]     r_read_addr;
  logic [logDepth-1:0]     r_write_addr;
  logic [width-1:0]        r_write_data;
  logic [logLineOffset-1:0] r_write_offset;
  logic                    r_write_enable;
  logic                    w_req_ready;

  // Ready is a pure decode of the state so an accept can happen on the very
  // first edge after reset is released.
  assign w_req_ready = (r_state == ST_IDLE);

  // Controller FSM: accept, single-cycle write strobe, latency count, response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= {CntW{1'b0}};
      r_resp_valid   <= 1'b0;
      r_resp_data    <= {width{1'b0}};
      r_read_addr    <= {logDepth{1'b0}};
      r_write_addr   <= {logDepth{1'b0}};
      r_write_data   <= {width{1'b0}};
      r_write_offset <= {logLineOffset{1'b0}};
      r_write_enable <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (reqValid) begin
            if (reqWrite) begin
              r_write_addr   <= reqAddr;
              r_write_data   <= reqData;
              r_write_offset <= reqOffset;
              r_write_enable <= 1'b1;
              r_state        <= ST_WRITE;
            end else begin
              r_read_addr <= reqAddr;
              r_cnt       <= CntW'(readLatency);
              r_state     <= ST_READ;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          // The SRAM commits the slice on this edge.
          r_write_enable <= 1'b0;
          r_state        <= ST_IDLE;
        end
        ST_READ: begin
          // Address stays put; the SRAM sampled it one edge after accept and
          // its data is stable once the count has run down to zero.
          if (r_cnt != {CntW{1'b0}}) begin
            r_cnt <= r_cnt - CntW'(1'b1);
          end else begin
            r_resp_data  <= sramReadData;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (respReady) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_resp_valid   <= 1'b0;
          r_write_enable <= 1'b0;
        end
      endcase
    end
  end

  assign reqReady        = w_req_ready;
  assign respValid       = r_resp_valid;
  assign respData        = r_resp_data;
  assign sramReadAddr    = r_read_addr;
  assign sramWriteAddr   = r_write_addr;
  assign sramWriteData   = r_write_data;
  assign sramWriteOffset = r_write_offset;
  assign sramWriteEnable = r_write_enable;

endmodule

// File: tb/tb_sram_requester.sv
// -----------------------------------------------------------------------------
// tb_sram_requester
//   Two requester instances (readLatency 1 / logDepth 9 and readLatency 3 /
//   logDepth 11), each attached to a behavioural SRAM. A line-array reference
//   model predicts every read line; randomized reads/writes follow the
//   directed scenarios.
// -----------------------------------------------------------------------------
module tb_sram_requester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid  [2];
  logic        req_write  [2];
  logic [10:0] req_addr   [2];
  logic [2:0]  req_off    [2];
  logic [15:0] req_data   [2];
  logic        resp_ready [2];

  wire         o_ready [2];
  wire         o_rv    [2];
  wire  [15:0] o_rd    [2];
  wire  [10:0] o_ra    [2];
  wire  [10:0] o_wa    [2];
  wire  [15:0] o_wd    [2];
  wire  [2:0]  o_wo    [2];
  wire         o_we    [2];

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ref_mem [2][2048];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LD = (g == 0) ? 9 : 11;
    localparam int RL = (g == 0) ? 1 : 3;

    wire  [LD-1:0] ra;
    wire  [LD-1:0] wa;
    wire  [15:0]   rdata;
    logic [15:0]   mem  [1<<LD];
    logic [15:0]   pipe [RL];

    sram_requester #(
      .width(16), .logDepth(LD), .logLineOffset(3), .readLatency(RL)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .reqValid(req_valid[g]), .reqReady(o_ready[g]), .reqWrite(req_write[g]),
      .reqAddr(req_addr[g][LD-1:0]), .reqOffset(req_off[g]), .reqData(req_data[g]),
      .respValid(o_rv[g]), .respReady(resp_ready[g]), .respData(o_rd[g]),
      .sramReadAddr(ra), .sramWriteAddr(wa), .sramWriteData(o_wd[g]),
      .sramWriteOffset(o_wo[g]), .sramWriteEnable(o_we[g]), .sramReadData(rdata)
    );

    assign o_ra[g] = 11'(ra);
    assign o_wa[g] = 11'(wa);
    assign rdata   = pipe[RL-1];

    initial begin
      for (int k = 0; k < (1 << LD); k++) mem[k] = 16'h0000;
      for (int k = 0; k < RL; k++) pipe[k] = 16'h0000;
    end

    // Behavioural SRAM: slice write and address sample on each edge, data
    // appears RL edges after the sample.
    always @(posedge clk) begin
      if (o_we[g]) mem[wa][o_wo[g]*2 +: 2] <= o_wd[g][o_wo[g]*2 +: 2];
      pipe[0] <= mem[ra];
      for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
  end

  function automatic int rl_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [10:0] amask(input int i);
    return (i == 0) ? 11'h1FF : 11'h7FF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (!o_ready[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(o_ready[i]), 32'd1);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_write(input int i, input logic [10:0] a, input logic [2:0] off,
                          input logic [15:0] d);
    logic [15:0] m;
    wait_ready(i);
    req_valid[i] = 1'b1; req_write[i] = 1'b1; req_addr[i] = a;
    req_off[i] = off; req_data[i] = d;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    chk("wr_en", 32'(o_we[i]), 32'd1);
    chk("wr_addr", 32'(o_wa[i]), 32'(a));
    chk("wr_off", 32'(o_wo[i]), 32'(off));
    chk("wr_slice", 32'((o_wd[i] >> (2*off)) & 16'h3), 32'((d >> (2*off)) & 16'h3));
    chk("wr_busy", 32'(o_ready[i]), 32'd0);
    m = 16'h0003 << (2*off);
    ref_mem[i][a] = (ref_mem[i][a] & ~m) | (d & m);
    @(posedge clk); #1;
    chk("wr_en_drop", 32'(o_we[i]), 32'd0);
    chk("wr_ready", 32'(o_ready[i]), 32'd1);
    chk("wr_no_resp", 32'(o_rv[i]), 32'd0);
  endtask

  task automatic do_read(input int i, input logic [10:0] a, input int hold);
    logic [15:0] exp;
    wait_ready(i);
    resp_ready[i] = 1'b0;
    req_valid[i] = 1'b1; req_write[i] = 1'b0; req_addr[i] = a;
    req_off[i] = 3'($urandom);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    exp = ref_mem[i][a];
    // Checked at accept edge E0 through E(readLatency): no response yet.
    for (int k = 0; k <= rl_of(i); k++) begin
      chk("rd_wait_rv", 32'(o_rv[i]), 32'd0);
      chk("rd_addr_hold", 32'(o_ra[i]), 32'(a));
      chk("rd_busy", 32'(o_ready[i]), 32'd0);
      @(posedge clk); #1;
    end
    chk("rd_rv", 32'(o_rv[i]), 32'd1);
    chk("rd_data", 32'(o_rd[i]), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      req_valid[i] = 1'b1; req_write[i] = 1'($urandom);
      req_addr[i] = 11'($urandom) & amask(i);
      @(posedge clk); #1;
      chk("bp_rv", 32'(o_rv[i]), 32'd1);
      chk("bp_data", 32'(o_rd[i]), 32'(exp));
      chk("bp_ready", 32'(o_ready[i]), 32'd0);
      chk("bp_addr", 32'(o_ra[i]), 32'(a));
      chk("bp_we", 32'(o_we[i]), 32'd0);
    end
    req_valid[i] = 1'b0;
    resp_ready[i] = 1'b1;
    @(posedge clk); #1;
    resp_ready[i] = 1'b0;
    chk("resp_done_rv", 32'(o_rv[i]), 32'd0);
    chk("resp_done_ready", 32'(o_ready[i]), 32'd1);
    chk("resp_done_addr", 32'(o_ra[i]), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] beef;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2048; k++) ref_mem[i][k] = 16'h0000;
      req_valid[i] = 1'b1; req_write[i] = 1'(i); req_addr[i] = 11'($urandom) & amask(i);
      req_off[i] = 3'($urandom); req_data[i] = 16'($urandom); resp_ready[i] = 1'b0;
    end

    // Reset held with requests pending: everything stays cleared.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rv", 32'(o_rv[i]), 32'd0);
      chk("rst_rd", 32'(o_rd[i]), 32'd0);
      chk("rst_ra", 32'(o_ra[i]), 32'd0);
      chk("rst_wa", 32'(o_wa[i]), 32'd0);
      chk("rst_wd", 32'(o_wd[i]), 32'd0);
      chk("rst_wo", 32'(o_wo[i]), 32'd0);
      chk("rst_we", 32'(o_we[i]), 32'd0);
    end
    @(negedge clk);
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_ready0", 32'(o_ready[0]), 32'd1);
    chk("rel_ready1", 32'(o_ready[1]), 32'd1);
    @(posedge clk); #1;
    chk("rel_idle_we", 32'(o_we[1]), 32'd0);
    chk("rel_idle_ready", 32'(o_ready[1]), 32'd1);

    // Read-after-write, readLatency 1: slice 3 of line 5, other slices kept.
    do_write(0, 11'd5, 3'd0, 16'hFFFF);
    do_write(0, 11'd5, 3'd3, 16'h00C0);
    do_read(0, 11'd5, 0);
    do_write(0, 11'd5, 3'd5, 16'h0800);
    do_read(0, 11'd5, 1);

    // readLatency 3: line 0x7FF built slice by slice, then read under back-pressure.
    beef = 16'hBEEF;
    for (int k = 0; k < 8; k++) do_write(1, 11'h7FF, 3'(k), beef);
    do_read(1, 11'h7FF, 5);

    // Reset while instance 1 has cnt==1 and instance 0 strobes a write.
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 11'h7FF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 11'd7;
    req_off[0] = 3'd1; req_data[0] = 16'hFFFF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("abort_we_pre", 32'(o_we[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(o_we[0]), 32'd0);
    chk("abort_ready", 32'(o_ready[1]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_rv", 32'(o_rv[1]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_post_rv", 32'(o_rv[1]), 32'd0);
    do_read(1, 11'h7FF, 0);
    do_read(0, 11'd7, 0);

    // Random mix on a small address pool so reads hit written lines.
    for (int n = 0; n < 60; n++) begin
      int i;
      logic [10:0] a;
      i = int'($urandom_range(0, 1));
      a = (($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 7))) & amask(i);
      if ($urandom_range(0, 1) == 1) begin
        do_write(i, a, 3'($urandom), 16'($urandom));
      end else begin
        do_read(i, a, int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
